// File: rtl/br_resolve_unit.sv
// Branch resolution in AGEX: detects next-PC mispredicts and redirects fetch in the same cycle.
// It also queues predictor training records for FE and keeps saturating branch/mispredict counts.
//
// state  | meaning
// IDLE   | resolutions are accepted, enqueued and compared against the prediction
// SQUASH | wrong-path resolutions are dropped for SQUASH_CYCLES cycles after a redirect
module br_resolve_unit #(
  parameter int DBITS         = 32,
  parameter int PHT_IDX_BITS  = 8,
  parameter int FIFO_DEPTH    = 2,
  parameter int SQUASH_CYCLES = 2,
  parameter int CNT_BITS      = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    res_valid,
  input  logic [DBITS-1:0]        res_pc,
  input  logic [DBITS-1:0]        res_pcplus,
  input  logic                    res_taken,
  input  logic [DBITS-1:0]        res_target,
  input  logic [DBITS-1:0]        res_pred_next_pc,
  input  logic [PHT_IDX_BITS-1:0] res_pht_index,
  output logic                    stall_out,
  output logic                    br_mispred_out,
  output logic [DBITS-1:0]        br_target_out,
  output logic                    upd_valid,
  input  logic                    upd_ready,
  output logic [DBITS-1:0]        upd_pc,
  output logic [DBITS-1:0]        upd_target,
  output logic [PHT_IDX_BITS-1:0] upd_pht_index,
  output logic                    upd_taken,
  output logic [CNT_BITS-1:0]     cnt_branches,
  output logic [CNT_BITS-1:0]     cnt_mispred
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int SQ_W  = (SQUASH_CYCLES > 1) ? $clog2(SQUASH_CYCLES) : 1;

  typedef enum logic {IDLE, SQUASH} state_t;

  state_t                  state_q;
  logic [SQ_W-1:0]         squash_q;
  logic [PTR_W-1:0]        rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [CNT_BITS-1:0]     cnt_br_q, cnt_mis_q;

  logic [DBITS-1:0]        pc_mem  [FIFO_DEPTH];
  logic [DBITS-1:0]        tgt_mem [FIFO_DEPTH];
  logic [PHT_IDX_BITS-1:0] pht_mem [FIFO_DEPTH];
  logic                    tk_mem  [FIFO_DEPTH];

  logic [DBITS-1:0] correct_pc;
  logic             accept, mispredict, push, pop;

  // Stall depends only on registered state so FE's upd_ready never feeds back into AGEX.
  assign stall_out  = (count_q == CNT_W'(FIFO_DEPTH)) && (state_q == IDLE);
  assign correct_pc = res_taken ? res_target : res_pcplus;
  assign accept     = res_valid && !stall_out && (state_q == IDLE);
  assign mispredict = accept && (correct_pc != res_pred_next_pc);

  assign br_mispred_out = mispredict;
  assign br_target_out  = mispredict ? correct_pc : '0;

  assign upd_valid = (count_q != '0);
  assign push      = accept;
  assign pop       = upd_valid && upd_ready;

  assign upd_pc        = upd_valid ? pc_mem[rd_ptr_q]  : '0;
  assign upd_target    = upd_valid ? tgt_mem[rd_ptr_q] : '0;
  assign upd_pht_index = upd_valid ? pht_mem[rd_ptr_q] : '0;
  assign upd_taken     = upd_valid ? tk_mem[rd_ptr_q]  : 1'b0;

  assign cnt_branches = cnt_br_q;
  assign cnt_mispred  = cnt_mis_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      squash_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mispredict) begin
            state_q  <= SQUASH;
            squash_q <= SQ_W'(SQUASH_CYCLES - 1);
          end
        end
        SQUASH: begin
          if (squash_q == '0) state_q <= IDLE;
          else                squash_q <= squash_q - SQ_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: the head is masked by upd_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]  <= res_pc;
      tgt_mem[wr_ptr_q] <= res_target;
      pht_mem[wr_ptr_q] <= res_pht_index;
      tk_mem[wr_ptr_q]  <= res_taken;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_br_q  <= '0;
      cnt_mis_q <= '0;
    end else begin
      if (accept && (cnt_br_q != '1))      cnt_br_q  <= cnt_br_q + CNT_BITS'(1);
      if (mispredict && (cnt_mis_q != '1)) cnt_mis_q <= cnt_mis_q + CNT_BITS'(1);
    end
  end

endmodule
